// File: rtl/axi_mem_slave.sv
// AXI4 subordinate backed by a synchronous single-port word RAM.
// Serves cache line refills (read bursts) and writebacks (write bursts), one
// transaction at a time.
// Ports:
//   i_aclk, i_areset          clock, asynchronous active-high reset
//   i_aw*/o_awready           write address channel
//   i_w*/o_wready             write data channel (i_wlast only checked, not used to end)
//   o_b*/i_bready             write response channel
//   i_ar*/o_arready           read address channel
//   o_r*/i_rready             read data channel
module axi_mem_slave #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned MEM_BYTES = 2**16,
  parameter int unsigned ID_BITS   = 4
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  input  logic [ID_BITS-1:0]     i_awid,
  input  logic [ADDR_SIZE-1:0]   i_awaddr,
  input  logic [7:0]             i_awlen,
  input  logic [2:0]             i_awsize,
  input  logic [1:0]             i_awburst,
  input  logic                   i_awvalid,
  output logic                   o_awready,
  input  logic [DATA_SIZE-1:0]   i_wdata,
  input  logic [DATA_SIZE/8-1:0] i_wstrb,
  input  logic                   i_wlast,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  output logic [ID_BITS-1:0]     o_bid,
  output logic [1:0]             o_bresp,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  input  logic [ID_BITS-1:0]     i_arid,
  input  logic [ADDR_SIZE-1:0]   i_araddr,
  input  logic [7:0]             i_arlen,
  input  logic [2:0]             i_arsize,
  input  logic [1:0]             i_arburst,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  output logic [ID_BITS-1:0]     o_rid,
  output logic [DATA_SIZE-1:0]   o_rdata,
  output logic [1:0]             o_rresp,
  output logic                   o_rlast,
  output logic                   o_rvalid,
  input  logic                   i_rready
);
  localparam int unsigned WordBytes = DATA_SIZE / 8;
  localparam int unsigned OffBits   = $clog2(WordBytes);
  localparam int unsigned MemBits   = $clog2(MEM_BYTES);
  localparam int unsigned Words     = MEM_BYTES / WordBytes;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [1:0]  RespDecErr = 2'b11;
  localparam logic [1:0]  BurstFixed = 2'b00;

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrData, StWrResp} state_e;

  state_e               state_q, state_d;
  logic                 prio_wr_q, prio_wr_d;  // 1: write wins the next tie
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [1:0]           burst_q, burst_d;
  logic                 bad_q, bad_d;          // unsupported burst type or size
  logic [1:0]           bresp_q, bresp_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 roor_q, roor_d;        // presented read beat is out of range

  logic [DATA_SIZE-1:0]       mem [Words];
  logic [DATA_SIZE-1:0]       mem_rdata_q;
  logic                       mem_re, mem_we;
  logic [ADDR_SIZE-1:0]       mem_addr, addr_nxt;
  logic [MemBits-OffBits-1:0] mem_idx;
  logic                       mem_oor, grant_rd, grant_wr, last_beat;
  logic [1:0]                 beat_resp, wr_code;

  assign addr_nxt  = (burst_q == BurstFixed) ? addr_q : addr_q + ADDR_SIZE'(WordBytes);
  // In RD_DATA the RAM is only enabled on a handshake, which fetches the next beat.
  assign mem_addr  = (state_q == StRdData) ? addr_nxt : addr_q;
  assign mem_idx   = mem_addr[MemBits-1:OffBits];
  assign mem_oor   = mem_addr >= ADDR_SIZE'(MEM_BYTES);
  assign beat_resp = mem_oor ? RespDecErr : (bad_q ? RespSlvErr : RespOkay);
  assign grant_rd  = i_arvalid && (!i_awvalid || !prio_wr_q);
  assign grant_wr  = i_awvalid && !grant_rd;
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    bad_d     = bad_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    roor_d    = roor_q;
    wr_code   = RespOkay;
    o_arready = 1'b0;
    o_awready = 1'b0;
    o_wready  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_arready = grant_rd;
        o_awready = grant_wr;
        if (grant_rd) begin
          id_d      = i_arid;
          addr_d    = i_araddr;
          len_d     = i_arlen;
          burst_d   = i_arburst;
          bad_d     = i_arburst[1] || (i_arsize != 3'(OffBits));
          cnt_d     = 8'd0;
          prio_wr_d = 1'b1;
          state_d   = StRdAddr;
        end else if (grant_wr) begin
          id_d      = i_awid;
          addr_d    = i_awaddr;
          len_d     = i_awlen;
          burst_d   = i_awburst;
          bad_d     = i_awburst[1] || (i_awsize != 3'(OffBits));
          cnt_d     = 8'd0;
          bresp_d   = RespOkay;
          prio_wr_d = 1'b0;
          state_d   = StWrData;
        end
      end
      StRdAddr: begin
        mem_re  = 1'b1;
        rresp_d = beat_resp;
        roor_d  = mem_oor;
        state_d = StRdData;
      end
      StRdData: begin
        if (i_rready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            mem_re  = 1'b1;
            rresp_d = beat_resp;
            roor_d  = mem_oor;
            addr_d  = addr_nxt;
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      StWrData: begin
        o_wready = 1'b1;
        if (i_wvalid) begin
          mem_we  = !mem_oor;
          wr_code = beat_resp;
          if ((i_wlast != last_beat) && (wr_code == RespOkay)) wr_code = RespSlvErr;
          // Codes order numerically as DECERR > SLVERR > OKAY.
          if (wr_code > bresp_q) bresp_d = wr_code;
          if (last_beat) begin
            state_d = StWrResp;
          end else begin
            addr_d = addr_nxt;
            cnt_d  = cnt_q + 8'd1;
          end
        end
      end
      StWrResp: begin
        if (i_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      bad_q     <= 1'b0;
      bresp_q   <= RespOkay;
      rresp_q   <= RespOkay;
      roor_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      bad_q     <= bad_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      roor_q    <= roor_d;
    end
  end

  // Contents survive reset; the FSM never enables read and write together.
  always_ff @(posedge i_aclk) begin
    if (mem_we) begin
      for (int k = 0; k < int'(WordBytes); k++) begin
        if (i_wstrb[k]) mem[mem_idx][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
    if (mem_re) mem_rdata_q <= mem[mem_idx];
  end

  assign o_rvalid = (state_q == StRdData);
  assign o_rdata  = (o_rvalid && !roor_q) ? mem_rdata_q : '0;
  assign o_rresp  = o_rvalid ? rresp_q : RespOkay;
  assign o_rlast  = o_rvalid && last_beat;
  assign o_rid    = id_q;
  assign o_bid    = id_q;
  assign o_bvalid = (state_q == StWrResp);
  assign o_bresp  = bresp_q;
endmodule
